// File: rtl/mem_burst_ctrl.sv
// Burst access controller in front of a single-port word memory.
// One command per burst (start address, beats-1, direction). Write beats
// are committed to memory on the edge they handshake. Read beats are
// registered into rdata and held under backpressure.
module mem_burst_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              rd_primed;    // first READ cycle only presents the address
    logic              last_loaded;  // final beat already sits in (or passed through) rdata

    logic              accept;
    logic              wr_beat;
    logic              rd_load;
    logic              rd_take;
    logic              rd_final;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, handshake strobes and combinational pin decode
    always_comb begin
        state_d     = state;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        mem_we      = 1'b0;
        accept      = 1'b0;
        wr_beat     = 1'b0;
        rd_load     = 1'b0;
        rd_take     = 1'b0;
        rd_final    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                accept    = cmd_valid;
                if (cmd_valid) begin
                    state_d = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wdata_ready = 1'b1;
                mem_we      = wdata_valid;
                wr_beat     = wdata_valid;
                if (wdata_valid && (remaining == '0)) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                rd_take  = rdata_valid && rdata_ready;
                rd_load  = rd_primed && !last_loaded && (!rdata_valid || rdata_ready);
                rd_final = last_loaded && rd_take;
                if (rd_final) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address/beat counters, read data register and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr    <= '0;
            remaining   <= '0;
            rd_primed   <= 1'b0;
            last_loaded <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                cur_addr    <= cmd_addr;
                remaining   <= cmd_len;
                rd_primed   <= 1'b0;
                last_loaded <= 1'b0;
            end
            if (state == READ) begin
                rd_primed <= 1'b1;
            end
            if (wr_beat) begin
                cur_addr <= cur_addr + ADDR_W'(1);
                if (remaining == '0) begin
                    done <= 1'b1;
                end else begin
                    remaining <= remaining - LEN_W'(1);
                end
            end
            if (rd_load) begin
                rdata       <= mem_dout;
                rdata_valid <= 1'b1;
                cur_addr    <= cur_addr + ADDR_W'(1);
                if (remaining == '0) begin
                    last_loaded <= 1'b1;
                end else begin
                    remaining <= remaining - LEN_W'(1);
                end
            end else if (rd_take) begin
                rdata_valid <= 1'b0;
            end
            if (rd_final) begin
                done <= 1'b1;
            end
        end
    end

    // Memory pins and status
    assign mem_addr = cur_addr;
    assign mem_din  = wdata;
    assign busy     = (state != IDLE);

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Burst access controller that sits directly upstream of the 1024x32 single-port word memory and drives its we/addr/din pins.
- Accepts one command per burst: a start address, a beat count and a direction.
- Write bursts stream data into the memory over a valid/ready channel.
- Read bursts stream memory words out through a registered valid/ready response channel with backpressure.

Parameters:
ADDR_W, 10, memory word-address width (depth 2**ADDR_W, wraps modulo depth)
DATA_W, 32, data word width
LEN_W, 8, burst length field width; beats = cmd_len + 1 (1..256)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command (high only in IDLE)
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  start word address
cmd_len  in  LEN_W  beats minus one
wdata_valid  in  1  write beat present
wdata_ready  out  1  write beat accepted this cycle
wdata  in  DATA_W  write beat data
rdata_valid  out  1  read beat present
rdata_ready  in  1  consumer takes read beat
rdata  out  DATA_W  read beat data (registered)
mem_we  out  1  to memory write enable
mem_addr  out  ADDR_W  to memory address
mem_din  out  DATA_W  to memory write data
mem_dout  in  DATA_W  from memory combinational read data
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on burst completion

Behaviour:
- Reset (async, rst_n low) clears all registers and takes effect immediately, independent of clk:
  - state=IDLE, cur_addr=0, remaining=0, rdata=0, rdata_valid=0, done=0.
  - Derived outputs: mem_we=0, cmd_ready=1, wdata_ready=0, busy=0.
- Memory pins:
  - mem_addr=cur_addr in all states.
  - mem_din=wdata combinationally.
  - mem_we=(state==WRITE)&&wdata_valid; never asserted in IDLE or READ.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: cur_addr<=cmd_addr, remaining<=cmd_len, state<=WRITE if cmd_write else READ.
- WRITE:
  - wdata_ready=1.
  - Each cycle with wdata_valid is one beat: the memory captures wdata at cur_addr on that edge, and cur_addr<=cur_addr+1 mod 2**ADDR_W.
  - If remaining==0 on that beat: state<=IDLE and done<=1. Otherwise remaining<=remaining-1.
  - Cycles without wdata_valid change nothing.
- READ:
  - A load occurs when beats remain unloaded and (!rdata_valid || rdata_ready).
  - On a load: rdata<=mem_dout, rdata_valid<=1, cur_addr increments (wrapping).
  - A last_loaded flag is set when the beat with remaining==0 loads; otherwise remaining decrements.
  - If rdata_valid&&rdata_ready and no new load: rdata_valid<=0.
  - When last_loaded and the final beat handshakes: state<=IDLE, done<=1.
  - rdata and rdata_valid are held stable while rdata_valid&&!rdata_ready.
- Latency:
  - Command accepted at edge E0; first rdata_valid high after edge E0+2 (one cycle in READ to present the address, then the registered load).
  - With rdata_ready held high, throughput is one beat per cycle.
  - A write beat is written on the same edge it handshakes.
- done:
  - Exactly one cycle, coincident with the first IDLE cycle after the burst.
  - A new command may be accepted in that same cycle.
- Boundaries:
  - Address wraps from 2**ADDR_W-1 to 0 within a burst.
  - cmd_len=0 gives a single beat.
  - cmd_len=255 gives 256 beats.
  - Commands presented while busy are not accepted (cmd_ready=0) and must be held by the source.
  - Reset mid-burst abandons the burst: no further mem_we, pending rdata dropped, no done pulse.

Test Plan:
- Write burst cmd_addr=0x3FE, cmd_len=3, wdata A0,A1,A2,A3 back-to-back -> memory 0x3FE=A0, 0x3FF=A1, 0x000=A2, 0x001=A3; mem_we high exactly 4 cycles; single done pulse.
- Read burst cmd_addr=0x3FE, cmd_len=3, rdata_ready=1 -> rdata A0,A1,A2,A3 on 4 consecutive cycles, first valid 2 cycles after accept; done pulse after the last beat.
- Read burst cmd_len=3 with rdata_ready toggling 1,0,1,0 -> each word held stable while stalled; order A0..A3 preserved; no beat lost or duplicated.
- Write burst cmd_addr=0x010, cmd_len=1, wdata_valid gapped (1,0,0,1) -> mem_we only on the 2 valid cycles; 0x010 and 0x011 written; done after the 2nd beat.
- cmd_valid held during an active burst -> cmd_ready=0 until the done cycle; the held command is accepted in the done cycle.
- rst_n low after 2 of 8 write beats -> mem_we=0 immediately; busy=0; no done; next burst starts cleanly from the new cmd_addr.
